program_feeder: RTL

Instruction-side responder for the 16-bit multicycle processor. It holds a small program buffer that the operator loads word-by-word from switches. It then serves instruction words on the processor's DIN input under a Run/Done handshake, advancing its program counter on each completed instruction. It replaces the free-running address counter plus ROM pair on the board top level.

---
 rtl/program_feeder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/program_feeder.sv
// Program buffer loaded word-by-word from switches, then served to the multicycle
// processor on DIN under a Run/Done handshake with optional looping and halting.
module program_feeder #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Load_wr,
   input  logic [DATA_W-1:0] Load_data,
   input  logic              Clear,
   input  logic              Start,
   input  logic              Stop,
   input  logic              Loop,
   input  logic              Proc_Done,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   output logic [ADDR_W-1:0] Pc,
   output logic [ADDR_W:0]   Prog_len,
   output logic              Full,
   output logic              Halted,
   output logic [15:0]       Instr_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W:0]     prog_len_q;
   logic [15:0]         count_q;
   logic                stop_pend_q;
   logic                run_q;
   logic                halted_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                full_d;
   logic                last_d;
   logic                wr_en_d;
   logic [15:0]         count_inc_d;

   assign full_d      = (prog_len_q == (ADDR_W+1)'(DEPTH));
   // Compare in ADDR_W+1 bits so Prog_len==DEPTH never aliases onto Pc
   assign last_d      = ({1'b0, pc_q} == (prog_len_q - (ADDR_W+1)'(1)));
   assign wr_en_d     = Resetn && (state_q == S_IDLE) && Load_wr && !Clear && !full_d;
   assign count_inc_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_ff @(posedge Clock) begin
      if (wr_en_d) begin
         mem[prog_len_q[ADDR_W-1:0]] <= Load_data;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         prog_len_q  <= '0;
         count_q     <= '0;
         stop_pend_q <= 1'b0;
         run_q       <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Clear) begin
                  prog_len_q <= '0;
               end else if (Load_wr) begin
                  if (!full_d) prog_len_q <= prog_len_q + (ADDR_W+1)'(1);
               end else if (Start && prog_len_q != '0) begin
                  state_q     <= S_RUN;
                  run_q       <= 1'b1;
                  pc_q        <= '0;
                  count_q     <= '0;
                  stop_pend_q <= 1'b0;
               end
            end
            S_RUN: begin
               if (Stop) stop_pend_q <= 1'b1;
               if (Proc_Done) begin
                  count_q <= count_inc_d;
                  if (stop_pend_q || Stop) begin
                     state_q  <= S_HALT;
                     run_q    <= 1'b0;
                     halted_q <= 1'b1;
                  end else if (last_d) begin
                     if (Loop) begin
                        pc_q <= '0;
                     end else begin
                        state_q  <= S_HALT;
                        run_q    <= 1'b0;
                        halted_q <= 1'b1;
                     end
                  end else begin
                     pc_q <= pc_q + ADDR_W'(1);
                  end
               end
            end
            S_HALT: begin
               if (Clear) begin
                  state_q    <= S_IDLE;
                  halted_q   <= 1'b0;
                  prog_len_q <= '0;
               end else if (Start) begin
                  state_q     <= S_RUN;
                  run_q       <= 1'b1;
                  halted_q    <= 1'b0;
                  pc_q        <= '0;
                  count_q     <= '0;
                  stop_pend_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               run_q    <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   // Asynchronous read off the registered Pc keeps DIN steady across the instruction
   assign DIN         = run_q ? mem[pc_q] : '0;
   assign Run         = run_q;
   assign Pc          = pc_q;
   assign Prog_len    = prog_len_q;
   assign Full        = full_d;
   assign Halted      = halted_q;
   assign Instr_count = count_q;

endmodule
